// File: rtl/pcm16_to_double_if.sv
// Handshake bundle for the PCM16 to IEEE-754 double converter.
// The sample side and the result side both use valid/ready; busy is a status flag.
interface pcm16_to_double_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sample;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_double;
  logic        busy;

  modport master (
    output in_valid,
    output in_sample,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_double,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_double,
    output busy
  );
endinterface

// File: rtl/pcm16_to_double.sv
// Converts signed 16-bit PCM samples to IEEE-754 doubles scaled by 2^SCALE_EXP,
// normalising the magnitude one left shift per clock.
module pcm16_to_double #(
  parameter int SCALE_EXP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pcm16_to_double_if.slave      bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    NORM = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_t;

  // Bias and scale fold into one constant; the legal scale range keeps it positive.
  localparam logic [10:0] EXP_BASE = 11'(1023 + SCALE_EXP);

  function automatic logic [15:0] magnitude16(input logic [15:0] s);
    magnitude16 = s[15] ? (~s + 16'd1) : s;
  endfunction

  state_t      state_r, state_next_s;
  logic [15:0] sample_r, sample_next_s;
  logic        sign_r, sign_next_s;
  logic [15:0] mag_r, mag_next_s;
  logic [3:0]  e_r, e_next_s;
  logic [63:0] dbl_r, dbl_next_s;
  logic        out_valid_r, out_valid_next_s;
  logic [10:0] exp_field_s;

  assign exp_field_s    = EXP_BASE + {7'd0, e_r};
  assign bus.in_ready   = (state_r == IDLE) && !rst;
  assign bus.busy       = (state_r != IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.out_double = dbl_r;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sample_r    <= 16'd0;
      sign_r      <= 1'b0;
      mag_r       <= 16'd0;
      e_r         <= 4'd0;
      dbl_r       <= 64'd0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      sample_r    <= sample_next_s;
      sign_r      <= sign_next_s;
      mag_r       <= mag_next_s;
      e_r         <= e_next_s;
      dbl_r       <= dbl_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

  // Next-state and datapath update for the accept/load/normalise/pack/deliver sequence.
  always_comb begin
    state_next_s     = state_r;
    sample_next_s    = sample_r;
    sign_next_s      = sign_r;
    mag_next_s       = mag_r;
    e_next_s         = e_r;
    dbl_next_s       = dbl_r;
    out_valid_next_s = out_valid_r;

    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          sample_next_s = bus.in_sample;
          state_next_s  = LOAD;
        end else begin
          state_next_s  = IDLE;
        end
      end

      LOAD: begin
        sign_next_s = sample_r[15];
        mag_next_s  = magnitude16(sample_r);
        e_next_s    = 4'd15;
        // A zero sample skips normalisation but still passes through PACK.
        if (sample_r == 16'd0) begin
          state_next_s = PACK;
        end else begin
          state_next_s = NORM;
        end
      end

      NORM: begin
        if (!mag_r[15]) begin
          mag_next_s   = {mag_r[14:0], 1'b0};
          e_next_s     = e_r - 4'd1;
          state_next_s = NORM;
        end else begin
          state_next_s = PACK;
        end
      end

      PACK: begin
        if (mag_r == 16'd0) begin
          dbl_next_s = 64'd0;
        end else begin
          dbl_next_s = {sign_r, exp_field_s, mag_r[14:0], 37'd0};
        end
        out_valid_next_s = 1'b1;
        state_next_s     = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_next_s = 1'b0;
          state_next_s     = IDLE;
        end else begin
          out_valid_next_s = 1'b1;
          state_next_s     = DONE;
        end
      end

      default: begin
        out_valid_next_s = 1'b0;
        state_next_s     = IDLE;
      end
    endcase
  end

endmodule
